// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes after ID and returns a stall request or EXE forwarding selects.
// Latency: stall/fwd_sel are combinational from ID inputs and the entry pipeline; entries advance every cycle.
// Backpressure: stall freezes IF/ID and injects a bubble into EXE; post-ID stages never stall.
module hazard_scoreboard #(
    parameter int REG_W    = 4,
    parameter int STAGES   = 2,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_en,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             flush,
    output logic             stall,
    output logic [SW-1:0]    fwd_sel1,
    output logic [SW-1:0]    fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wb;
        logic             ld;
    } entry_t;

    entry_t e [1:STAGES];

    logic          hit1, hit2;
    logic          blk1, blk2;
    logic [SW-1:0] sel1, sel2;

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        blk1 = 1'b0;
        blk2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (e[k].v && e[k].wb && id_src1_en && (e[k].dest == id_src1)) begin
                hit1 = 1'b1;
                sel1 = SW'(k);
                blk1 = e[k].ld && (k <= LOAD_LAT);
            end
            if (e[k].v && e[k].wb && id_src2_en && (e[k].dest == id_src2)) begin
                hit2 = 1'b1;
                sel2 = SW'(k);
                blk2 = e[k].ld && (k <= LOAD_LAT);
            end
        end
    end

    always_comb begin
        stall    = 1'b0;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if (FWD_EN != 0) begin
            stall    = id_valid && (blk1 || blk2);
            fwd_sel1 = sel1;
            fwd_sel2 = sel2;
        end else begin
            stall = id_valid && (hit1 || hit2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                e[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                e[k] <= e[k-1];
            end
            e[1].v    <= id_valid && !stall && !flush;
            e[1].dest <= id_dest;
            e[1].wb   <= id_wb_en;
            e[1].ld   <= id_mem_r_en;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: forwarding, stall-only and narrow-counter instances share one ID input stream.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_src1_en, id_src2_en, id_wb_en, id_mem_r_en, flush;

    logic        fw_stall, so_stall, sat_stall;
    logic [1:0]  fw_sel1, fw_sel2, so_sel1, so_sel2, sat_sel1, sat_sel2;
    logic [15:0] fw_cnt, so_cnt;
    logic [1:0]  sat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut_fw (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_src2_en(id_src2_en),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .flush(flush), .stall(fw_stall), .fwd_sel1(fw_sel1), .fwd_sel2(fw_sel2),
        .stall_cnt(fw_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0)) dut_so (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_src2_en(id_src2_en),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .flush(flush), .stall(so_stall), .fwd_sel1(so_sel1), .fwd_sel2(so_sel2),
        .stall_cnt(so_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_src2_en(id_src2_en),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .flush(flush), .stall(sat_stall), .fwd_sel1(sat_sel1), .fwd_sel2(sat_sel2),
        .stall_cnt(sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Arguments: valid, src1, src1_en, src2, src2_en, dest, wb, ld, flush
    task automatic drive(input int v, input int s1, input int s1e, input int s2, input int s2e,
                         input int d, input int wb, input int ld, input int fl);
        id_valid    = 1'(v);
        id_src1     = 4'(s1);
        id_src1_en  = 1'(s1e);
        id_src2     = 4'(s2);
        id_src2_en  = 1'(s2e);
        id_dest     = 4'(d);
        id_wb_en    = 1'(wb);
        id_mem_r_en = 1'(ld);
        flush       = 1'(fl);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom_range(15), $urandom_range(1), $urandom_range(15), $urandom_range(1),
                  $urandom_range(15), $urandom_range(1), $urandom_range(1), $urandom_range(1));
            tick();
        end
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(fw_stall), 0);
        chk("rst_sel1", 32'(fw_sel1), 0);
        chk("rst_sel2", 32'(fw_sel2), 0);
        chk("rst_cnt", 32'(fw_cnt), 0);
        chk("rst_so_stall", 32'(so_stall), 0);

        // Back-to-back dependency forwards from EXE
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 9, 0, 0, 0);
        chk("fwd1_stall", 32'(fw_stall), 0);
        chk("fwd1_sel1", 32'(fw_sel1), 1);

        // One unrelated instruction in between
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 9, 0, 0, 0);
        chk("fwd2_stall", 32'(fw_stall), 0);
        chk("fwd2_sel1", 32'(fw_sel1), 2);

        // Two unrelated instructions: producer already retired
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 9, 0, 0, 0);
        chk("fwd0_stall", 32'(fw_stall), 0);
        chk("fwd0_sel1", 32'(fw_sel1), 0);

        // Load-use: one stall, then forward from stage 2
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();
        drive(1, 0, 0, 2, 1, 9, 1, 0, 0);
        chk("ldu_stall_a", 32'(fw_stall), 1);
        tick();
        drive(1, 0, 0, 2, 1, 9, 1, 0, 0);
        chk("ldu_stall_b", 32'(fw_stall), 0);
        chk("ldu_sel2", 32'(fw_sel2), 2);
        chk("ldu_cnt", 32'(fw_cnt), 1);
        tick();
        idle();
        chk("ldu_cnt_hold", 32'(fw_cnt), 1);

        // Flush during a load-use stall: stall still reported, next ID forwards cleanly
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();
        drive(1, 0, 0, 2, 1, 9, 1, 0, 1);
        chk("flst_stall", 32'(fw_stall), 1);
        tick();
        drive(1, 0, 0, 2, 1, 12, 1, 0, 0);
        chk("flst_after_stall", 32'(fw_stall), 0);
        chk("flst_after_sel2", 32'(fw_sel2), 2);

        // Stall-only mode: two stall cycles, then the narrow counter saturates
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        drive(1, 3, 1, 0, 0, 11, 0, 0, 0);
        chk("so_stall_a", 32'(so_stall), 1);
        tick();
        drive(1, 3, 1, 0, 0, 11, 0, 0, 0);
        chk("so_stall_b", 32'(so_stall), 1);
        tick();
        drive(1, 3, 1, 0, 0, 11, 0, 0, 0);
        chk("so_stall_c", 32'(so_stall), 0);
        chk("so_sel1", 32'(so_sel1), 0);
        chk("so_cnt2", 32'(so_cnt), 2);
        chk("sat_cnt2", 32'(sat_cnt), 2);
        for (int p = 0; p < 2; p++) begin
            tick();
            drive(1, 0, 0, 0, 0, 8, 1, 0, 0); tick();
            drive(1, 0, 0, 8, 1, 11, 0, 0, 0);
            chk("sat_pair_stall", 32'(so_stall), 1);
            tick(); tick();
            drive(1, 0, 0, 8, 1, 11, 0, 0, 0);
            chk("sat_pair_clear", 32'(so_stall), 0);
        end
        chk("so_cnt6", 32'(so_cnt), 6);
        chk("sat_cnt_sat", 32'(sat_cnt), 3);

        // Stall-only, dependency first seen at stage 2: single stall cycle
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        drive(1, 3, 1, 0, 0, 11, 0, 0, 0);
        chk("so_e2_stall", 32'(so_stall), 1);
        tick();
        drive(1, 3, 1, 0, 0, 11, 0, 0, 0);
        chk("so_e2_clear", 32'(so_stall), 0);
        chk("so_e2_cnt", 32'(so_cnt), 1);

        // Youngest producer wins
        do_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
        drive(1, 4, 1, 0, 0, 9, 0, 0, 0);
        chk("yw_stall", 32'(fw_stall), 0);
        chk("yw_sel1", 32'(fw_sel1), 1);
        chk("yw_so_stall", 32'(so_stall), 1);

        // Same sequence with the source disabled
        do_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
        drive(1, 4, 0, 0, 0, 9, 0, 0, 0);
        chk("dis_stall", 32'(fw_stall), 0);
        chk("dis_sel1", 32'(fw_sel1), 0);
        chk("dis_so_stall", 32'(so_stall), 0);

        // Flushed load never becomes a producer
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 1); tick();
        drive(1, 5, 1, 0, 0, 9, 0, 0, 0);
        chk("fl_stall", 32'(fw_stall), 0);
        chk("fl_sel1", 32'(fw_sel1), 0);
        chk("fl_so_stall", 32'(so_stall), 0);

        // Mid-operation reset drops in-flight producers and the counter
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0); tick();
        rst = 1'b1;
        drive(1, 6, 1, 0, 0, 9, 0, 0, 0); tick();
        rst = 1'b0;
        drive(1, 6, 1, 6, 1, 9, 0, 0, 0);
        chk("mrst_stall", 32'(fw_stall), 0);
        chk("mrst_sel1", 32'(fw_sel1), 0);
        chk("mrst_so_stall", 32'(so_stall), 0);
        chk("mrst_cnt", 32'(fw_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
